axil4_wr_arbiter: RTL and testbench

AXIL4_WR_ARBITER -- requirements
Module: axil4_wr_arbiter

---
 rtl/axil4_arb_pkg.sv | 15 +
 rtl/arbiter_rr_select.sv | 33 +++
 rtl/axil4_wr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_axil4_wr_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil4_arb_pkg.sv
// Purpose: shared types and constants for the AXI-Lite write arbiter.
// Contents: FSM state encoding and the BRESP codes used by requesters and bench.
// Ports: none (package).
package axil4_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/arbiter_rr_select.sv
// Purpose: round-robin pick of the first set request at or after a pointer, wrapping at N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the pick.
// Ports: i_req request vector, i_ptr search start; o_found any request set, o_idx chosen index.
module arbiter_rr_select #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        int w_cand;
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        // Walk from the farthest candidate back to the pointer so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/axil4_wr_arbiter.sv
// Purpose: N-to-1 AXI-Lite write arbiter, one outstanding transaction, round-robin grants.
// Latency: grant registered one cycle after AW request; AW/W/B forwarded combinationally once granted.
// Backpressure: non-granted requesters see ready=0; downstream B is held off (m_bready=0) outside RESP.
// Ports: aclk/areset (sync, active high); req_* packed per-requester AW/W/B lanes (slice i = requester i);
//        m_* single downstream AW/W/B channel; grant_id/grant_valid current owner; busy activity flag.
module axil4_wr_arbiter
    import axil4_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_DATA_WIDTH = 32
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [NUM_REQ*AXIL_ADDR_WIDTH-1:0]     req_awaddr,
    input  logic [NUM_REQ*3-1:0]                   req_awprot,
    input  logic [NUM_REQ-1:0]                     req_awvalid,
    output logic [NUM_REQ-1:0]                     req_awready,
    input  logic [NUM_REQ*AXIL_DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*(AXIL_DATA_WIDTH/8)-1:0] req_wstrb,
    input  logic [NUM_REQ-1:0]                     req_wvalid,
    output logic [NUM_REQ-1:0]                     req_wready,
    output logic [NUM_REQ*2-1:0]                   req_bresp,
    output logic [NUM_REQ-1:0]                     req_bvalid,
    input  logic [NUM_REQ-1:0]                     req_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]             m_awaddr,
    output logic [2:0]                             m_awprot,
    output logic                                   m_awvalid,
    input  logic                                   m_awready,
    output logic [AXIL_DATA_WIDTH-1:0]             m_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0]           m_wstrb,
    output logic                                   m_wvalid,
    input  logic                                   m_wready,
    input  logic [1:0]                             m_bresp,
    input  logic                                   m_bvalid,
    output logic                                   m_bready,
    output logic [$clog2(NUM_REQ)-1:0]             grant_id,
    output logic                                   grant_valid,
    output logic                                   busy
);

    localparam int AW = AXIL_ADDR_WIDTH;
    localparam int DW = AXIL_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int GW = $clog2(NUM_REQ);

    arb_state_e         r_state, w_state_nxt;
    logic [GW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic [GW-1:0]      r_grant_id, w_grant_id_nxt;
    logic               r_grant_valid, w_grant_valid_nxt;
    logic               r_aw_done, w_aw_done_nxt;
    logic               r_w_done, w_w_done_nxt;
    logic               w_pick_found;
    logic [GW-1:0]      w_pick_idx;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic               w_sel_awvalid, w_sel_wvalid, w_sel_bready;
    logic               w_aw_hs, w_w_hs;

    arbiter_rr_select #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_rr_select (
        .i_req   (req_awvalid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    assign w_gnt_oh    = NUM_REQ'(1) << r_grant_id;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign busy        = (r_state != IDLE) || (|req_awvalid);

    // Payload always follows the registered owner; only valid/ready are state-gated.
    always_comb begin
        m_awaddr      = '0;
        m_awprot      = '0;
        m_wdata       = '0;
        m_wstrb       = '0;
        w_sel_awvalid = 1'b0;
        w_sel_wvalid  = 1'b0;
        w_sel_bready  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_oh[i]) begin
                m_awaddr      = req_awaddr[i*AW +: AW];
                m_awprot      = req_awprot[i*3 +: 3];
                m_wdata       = req_wdata[i*DW +: DW];
                m_wstrb       = req_wstrb[i*SW +: SW];
                w_sel_awvalid = req_awvalid[i];
                w_sel_wvalid  = req_wvalid[i];
                w_sel_bready  = req_bready[i];
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_grant_id_nxt    = r_grant_id;
        w_grant_valid_nxt = r_grant_valid;
        w_aw_done_nxt     = r_aw_done;
        w_w_done_nxt      = r_w_done;
        w_aw_hs           = 1'b0;
        w_w_hs            = 1'b0;
        req_awready       = '0;
        req_wready        = '0;
        req_bvalid        = '0;
        req_bresp         = '0;
        m_awvalid         = 1'b0;
        m_wvalid          = 1'b0;
        m_bready          = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_grant_id_nxt    = w_pick_idx;
                    w_grant_valid_nxt = 1'b1;
                    w_state_nxt       = XFER;
                end
            end
            XFER: begin
                // A completed channel is fenced off so no second beat can slip through.
                m_awvalid   = w_sel_awvalid && !r_aw_done;
                m_wvalid    = w_sel_wvalid && !r_w_done;
                req_awready = w_gnt_oh & {NUM_REQ{m_awready && !r_aw_done}};
                req_wready  = w_gnt_oh & {NUM_REQ{m_wready && !r_w_done}};
                w_aw_hs     = m_awvalid && m_awready;
                w_w_hs      = m_wvalid && m_wready;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt   = RESP;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else begin
                    w_aw_done_nxt = r_aw_done || w_aw_hs;
                    w_w_done_nxt  = r_w_done || w_w_hs;
                end
            end
            RESP: begin
                req_bvalid = w_gnt_oh & {NUM_REQ{m_bvalid}};
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_bresp[2*i +: 2] = w_gnt_oh[i] ? m_bresp : 2'b00;
                end
                m_bready = w_sel_bready;
                if (m_bvalid && w_sel_bready) begin
                    w_state_nxt       = IDLE;
                    w_grant_valid_nxt = 1'b0;
                    w_rr_ptr_nxt      = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + GW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_aw_done     <= w_aw_done_nxt;
            r_w_done      <= w_w_done_nxt;
        end
    end

endmodule

// File: tb/tb_axil4_wr_arbiter.sv
// Purpose: directed self-checking bench for axil4_wr_arbiter with four requesters.
// Latency: requester and downstream models drive at negedge+2, sample at negedge+3; checks at negedge+4.
// Backpressure: downstream ready/bready knobs per test, random in the final soak.
`timescale 1ns/1ps
module tb_axil4_wr_arbiter;
    import axil4_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int GW = 2;

    logic              aclk   = 1'b0;
    logic              areset = 1'b1;
    logic [N*AW-1:0]   req_awaddr  = '0;
    logic [N*3-1:0]    req_awprot  = '0;
    logic [N-1:0]      req_awvalid = '0;
    logic [N-1:0]      req_awready;
    logic [N*DW-1:0]   req_wdata   = '0;
    logic [N*SW-1:0]   req_wstrb   = '0;
    logic [N-1:0]      req_wvalid  = '0;
    logic [N-1:0]      req_wready;
    logic [N*2-1:0]    req_bresp;
    logic [N-1:0]      req_bvalid;
    logic [N-1:0]      req_bready  = '0;
    logic [AW-1:0]     m_awaddr;
    logic [2:0]        m_awprot;
    logic              m_awvalid;
    logic              m_awready   = 1'b0;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              m_wvalid;
    logic              m_wready    = 1'b0;
    logic [1:0]        m_bresp     = 2'b00;
    logic              m_bvalid    = 1'b0;
    logic              m_bready;
    logic [GW-1:0]     grant_id;
    logic              grant_valid;
    logic              busy;

    axil4_wr_arbiter #(
        .NUM_REQ(N), .AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .req_awaddr(req_awaddr), .req_awprot(req_awprot), .req_awvalid(req_awvalid), .req_awready(req_awready),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_wvalid(req_wvalid), .req_wready(req_wready),
        .req_bresp(req_bresp), .req_bvalid(req_bvalid), .req_bready(req_bready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .grant_id(grant_id), .grant_valid(grant_valid), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Requester model state
    logic [N-1:0] aw_pend   = '0;
    logic [N-1:0] w_pend    = '0;
    logic [N-1:0] bready_en = '1;
    logic [31:0]  aw_addr_q [N];
    logic [2:0]   aw_prot_q [N];
    logic [31:0]  w_data_q  [N];
    logic [3:0]   w_strb_q  [N];
    int           b_cnt     [N];
    logic [1:0]   last_bresp[N];
    bit           w_sticky  = 1'b0;
    int           refill_left = 0;

    // Downstream model state
    int           ds_aw_cnt = 0, ds_w_cnt = 0, ds_b_cnt = 0;
    logic [31:0]  ds_last_wdata = '0;
    bit           ds_aw_got = 0, ds_w_got = 0, ds_b_pend = 0;
    logic [1:0]   ds_bresp  = OKAY;
    bit           ds_w_en   = 1'b1;
    int           ds_aw_hold = 0;
    bit           ds_w_first = 1'b0;
    bit           rnd_mode  = 1'b0;

    // Monitors
    int           glog[$];
    bit           gv_prev = 1'b0;
    int           nongnt_viol = 0;
    int           sb_err = 0;

    task automatic set_aw(input int i, input logic [31:0] a);
        aw_addr_q[i] = a;
        aw_prot_q[i] = 3'(i);
        aw_pend[i]   = 1'b1;
    endtask

    task automatic set_w(input int i, input logic [31:0] d, input logic [3:0] s);
        w_data_q[i] = d;
        w_strb_q[i] = s;
        w_pend[i]   = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        set_aw(i, a);
        set_w(i, d, s);
    endtask

    function automatic int bsum();
        int s = 0;
        for (int i = 0; i < N; i++) s += b_cnt[i];
        return s;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            aw_addr_q[i] = '0; aw_prot_q[i] = '0; w_data_q[i] = '0; w_strb_q[i] = '0;
            b_cnt[i] = 0; last_bresp[i] = 2'b00;
        end
        forever begin
            @(negedge aclk);
            #2;
            for (int i = 0; i < N; i++) begin
                req_awvalid[i]         = aw_pend[i];
                req_awaddr[i*AW +: AW] = aw_addr_q[i];
                req_awprot[i*3 +: 3]   = aw_prot_q[i];
                req_wvalid[i]          = w_pend[i];
                req_wdata[i*DW +: DW]  = w_data_q[i];
                req_wstrb[i*SW +: SW]  = w_strb_q[i];
                req_bready[i]          = rnd_mode ? 1'($urandom_range(0, 1)) : bready_en[i];
            end
            m_awready = rnd_mode ? 1'($urandom_range(0, 1)) : (ds_aw_hold == 0);
            m_wready  = rnd_mode ? 1'($urandom_range(0, 1)) : ds_w_en;
            m_bvalid  = ds_b_pend;
            m_bresp   = ds_bresp;
            #1;
            if (areset) begin
                ds_aw_got = 0; ds_w_got = 0; ds_b_pend = 0; gv_prev = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if ((req_awready[i] || req_wready[i] || req_bvalid[i]) &&
                        !(grant_valid && grant_id == GW'(i)))
                        nongnt_viol++;
                    if (req_awvalid[i] && req_awready[i]) aw_pend[i] = 1'b0;
                    if (req_wvalid[i] && req_wready[i] && !w_sticky) w_pend[i] = 1'b0;
                    if (req_bvalid[i] && req_bready[i]) begin
                        b_cnt[i]++;
                        last_bresp[i] = req_bresp[2*i +: 2];
                        if (req_bresp[2*i +: 2] !== m_bresp || !m_bready) sb_err++;
                        if (refill_left > 0) begin
                            refill_left--;
                            set_req(i, $urandom, $urandom, 4'($urandom_range(1, 15)));
                        end
                    end
                end
                if (m_wvalid && m_wready) begin
                    ds_w_cnt++;
                    ds_last_wdata = m_wdata;
                    if (!ds_aw_got && !(m_awvalid && m_awready)) ds_w_first = 1'b1;
                    if (m_wdata !== w_data_q[grant_id] || m_wstrb !== w_strb_q[grant_id]) sb_err++;
                    ds_w_got = 1'b1;
                end
                if (m_awvalid && m_awready) begin
                    ds_aw_cnt++;
                    if (m_awaddr !== aw_addr_q[grant_id] || m_awprot !== aw_prot_q[grant_id]) sb_err++;
                    ds_aw_got = 1'b1;
                end else if (m_awvalid && ds_aw_hold > 0) begin
                    ds_aw_hold--;
                end
                if (m_bvalid && m_bready) begin
                    ds_b_pend = 1'b0;
                    ds_b_cnt++;
                end
                if (ds_aw_got && ds_w_got && !ds_b_pend) begin
                    ds_b_pend = 1'b1;
                    ds_aw_got = 1'b0;
                    ds_w_got  = 1'b0;
                    if (rnd_mode) ds_bresp = $urandom_range(0, 1) ? SLVERR : OKAY;
                end
                if (grant_valid && !gv_prev) glog.push_back(int'(grant_id));
                gv_prev = grant_valid;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge aclk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic wait_b(input string tag, input int i, input int target, input int budget, output int cycles);
        cycles = 0;
        while (b_cnt[i] < target && cycles < budget) begin
            tick(); settle(); cycles++;
        end
        check(tag, b_cnt[i] >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, b0, b1, b3, aw0, w0, g0, bs0, dsb0;
        int gc[N];
        int rot_exp[6];
        rot_exp = '{0, 1, 2, 3, 0, 1};

        // Reset state
        tick(2); settle();
        check("rst_grant_valid", grant_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_m_valids", {m_awvalid, m_wvalid, m_bready}, 3'b000);
        check("rst_req_bvalid", req_bvalid, 0);
        check("rst_req_readies", {req_awready, req_wready}, 0);
        tick(); areset = 1'b0;

        // Single request on requester 0, downstream always ready
        tick(); set_req(0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF); settle();
        check("single_busy_idle", busy, 1);
        check("single_idle_no_grant", {grant_valid, m_awvalid, m_wvalid}, 3'b000);
        tick(); settle();
        check("single_grant", {grant_valid, grant_id}, {1'b1, 2'd0});
        check("single_awaddr", m_awaddr, 32'h0000_1000);
        check("single_wdata", {m_wdata, m_wstrb}, {32'hDEAD_BEEF, 4'hF});
        check("single_valids", {m_awvalid, m_wvalid}, 2'b11);
        check("single_awready_oh", req_awready, 4'b0001);
        wait_b("single_b_timeout", 0, 1, 10, cyc);
        check("single_b_latency", cyc, 1);
        check("single_b_only_req0", bsum(), 1);
        check("single_bresp", last_bresp[0], OKAY);
        tick(); settle();
        check("single_busy_after", {busy, grant_valid}, 2'b00);

        // Fair rotation with all requesters asserting continuously
        tick(); areset = 1'b1;
        tick(); areset = 1'b0;
        glog.delete(); nongnt_viol = 0; refill_left = 1000;
        for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), 32'hA0 + i, 4'hF);
        cyc = 0;
        while (glog.size() < 6 && cyc < 100) begin tick(); settle(); cyc++; end
        refill_left = 0;
        for (int k = 0; k < 6; k++)
            check($sformatf("rot_grant%0d", k), (k < glog.size()) ? glog[k] : -1, rot_exp[k]);
        cyc = 0;
        while (((aw_pend | w_pend) != 0 || grant_valid) && cyc < 100) begin tick(); settle(); cyc++; end
        check("rot_drain_timeout", cyc < 100, 1);
        check("rot_nongrant_ready", nongnt_viol, 0);

        // W leads AW by 3 cycles, AW ready withheld for 5 cycles
        aw0 = ds_aw_cnt; w0 = ds_w_cnt; b0 = b_cnt[0]; g0 = glog.size(); ds_w_first = 1'b0;
        tick(); w_sticky = 1'b1; ds_aw_hold = 5; set_w(0, 32'h1234_5678, 4'h3); settle();
        check("wlead_no_grant", {grant_valid, req_wready[0], busy}, 3'b000);
        tick(3); set_aw(0, 32'h0000_2000);
        tick(2); settle();
        check("wlead_w_fenced", {m_wvalid, req_wready[0], req_wvalid[0]}, 3'b001);
        check("wlead_aw_waiting", {m_awvalid, req_awready[0], grant_valid}, 3'b101);
        check("wlead_one_w_beat", ds_w_cnt - w0, 1);
        wait_b("wlead_b_timeout", 0, b0 + 1, 30, cyc);
        w_sticky = 1'b0; w_pend[0] = 1'b0;
        check("wlead_w_first", ds_w_first, 1);
        check("wlead_counts", {16'(ds_aw_cnt - aw0), 16'(ds_w_cnt - w0)}, {16'd1, 16'd1});
        check("wlead_one_grant", glog.size() - g0, 1);
        tick(2); settle();
        check("wlead_one_resp", b_cnt[0] - b0, 1);

        // SLVERR routed to requester 1 with requester bready held low 4 cycles
        ds_bresp = SLVERR; bready_en[1] = 1'b0; b1 = b_cnt[1];
        tick(); set_req(1, 32'h0000_3000, 32'hCAFE_F00D, 4'hC); settle();
        cyc = 0;
        while (!m_bvalid && cyc < 20) begin tick(); settle(); cyc++; end
        check("slverr_bvalid_seen", m_bvalid, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin tick(); settle(); end
            check($sformatf("slverr_hold%0d_bvalid", k), req_bvalid, 4'b0010);
            check($sformatf("slverr_hold%0d_resp", k), {req_bresp, m_bready}, {8'b0000_1000, 1'b0});
        end
        bready_en[1] = 1'b1;
        tick(); settle();
        check("slverr_bready_pass", m_bready, 1);
        check("slverr_delivered", {b_cnt[1] - b1, 30'(last_bresp[1])}, {32'd1, 30'(SLVERR)});
        ds_bresp = OKAY;

        // Reset while in XFER after AW only
        ds_w_en = 1'b0;
        tick(); set_req(1, 32'h0000_4000, 32'h5555_AAAA, 4'hF); settle();
        tick(2); settle();
        check("rstx_aw_done_w_open", {m_awvalid, m_wvalid, grant_id}, {1'b0, 1'b1, 2'd1});
        b1 = b_cnt[1]; b3 = b_cnt[3];
        tick(); areset = 1'b1; settle();
        tick(); settle();
        check("rstx_idle", {grant_valid, m_awvalid, m_wvalid, m_bready}, 4'b0000);
        check("rstx_no_b", {req_bvalid, req_wready, req_awready}, 0);
        w_pend[1] = 1'b0; ds_w_en = 1'b1; areset = 1'b0;
        g0 = glog.size();
        tick(); set_req(1, 32'h0000_5000, 32'h1111_2222, 4'hF); set_req(3, 32'h0000_6000, 32'h3333_4444, 4'hF);
        cyc = 0;
        while ((b_cnt[1] == b1 || b_cnt[3] == b3) && cyc < 40) begin tick(); settle(); cyc++; end
        check("rstx_first_after_reset", (glog.size() > g0) ? glog[g0] : -1, 1);
        check("rstx_second", (glog.size() > g0 + 1) ? glog[g0 + 1] : -1, 3);
        check("rstx_b_counts", {b_cnt[1] - b1, b_cnt[3] - b3}, {32'd1, 32'd1});

        // Random backpressure soak: 200 transactions, data/response scoreboard
        sb_err = 0; nongnt_viol = 0; g0 = glog.size(); bs0 = bsum(); dsb0 = ds_b_cnt;
        tick(); rnd_mode = 1'b1; refill_left = 196;
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 4'($urandom_range(1, 15)));
        cyc = 0;
        while (bsum() - bs0 < 200 && cyc < 20000) begin tick(); settle(); cyc++; end
        rnd_mode = 1'b0;
        tick(3); settle();
        check("soak_b_total", bsum() - bs0, 200);
        check("soak_ds_b_total", ds_b_cnt - dsb0, 200);
        check("soak_scoreboard", sb_err, 0);
        check("soak_nongrant_ready", nongnt_viol, 0);
        check("soak_idle_end", {aw_pend, w_pend, grant_valid, busy}, 0);
        for (int i = 0; i < N; i++) gc[i] = 0;
        for (int k = g0; k < glog.size(); k++) gc[glog[k]]++;
        for (int i = 0; i < N; i++) check($sformatf("soak_fair%0d", i), gc[i], 50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
